threshold_trigger_ctrl: RTL

// - Sequencer placed after the scaled-threshold comparator. It consumes the comparator's 1-bit
//   "threshold met" AXI stream and qualifies bursts using an on-count, an off-count and a holdoff.
// - Fires a one-cycle trigger when a burst is qualified.
// - Emits one 32-bit burst-length report per completed burst on an AXI output stream.
// - All settings are written through the standard settings bus.

---
 rtl/threshold_ctrl_pkg.sv | 26 ++
 rtl/threshold_report_reg.sv | 66 ++++++
 rtl/threshold_trigger_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/threshold_ctrl_pkg.sv
// Shared types and constants for threshold_trigger_ctrl.
// THRESH_CTRL_TIMESTAMP_EN switches the report from 1 word to 3 words (len, ts_hi, ts_lo).
package threshold_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEARCH  = 3'd1,
    QUALIFY = 3'd2,
    ACTIVE  = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  localparam logic [7:0] SR_CTRL = 8'd0;
  localparam logic [7:0] SR_ON   = 8'd1;
  localparam logic [7:0] SR_OFF  = 8'd2;
  localparam logic [7:0] SR_HOLD = 8'd3;

  localparam int unsigned OVF_W = 16;

`ifdef THRESH_CTRL_TIMESTAMP_EN
  localparam int unsigned RPT_WORDS = 3;
`else
  localparam int unsigned RPT_WORDS = 1;
`endif

endpackage

// File: rtl/threshold_report_reg.sv
// Single-entry report buffer: serialises a WORDS-long report onto an AXI stream and
// drops (and counts) any report that arrives while the previous one is still pending.
module threshold_report_reg
  import threshold_ctrl_pkg::*;
#(
  parameter int unsigned LEN_W = 32,
  parameter int unsigned WORDS = RPT_WORDS
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [WORDS-1:0][LEN_W-1:0] push_data,
  output logic [LEN_W-1:0]            o_tdata,
  output logic                        o_tlast,
  output logic                        o_tvalid,
  input  logic                        o_tready,
  output logic [OVF_W-1:0]            ovf_count
);

  localparam int unsigned CW = 2;

  logic [WORDS-1:0][LEN_W-1:0] words_q;
  logic [CW-1:0]               left_q;
  logic                        hs_c;
  logic                        fin_c;

  assign hs_c    = o_tvalid & o_tready;
  assign fin_c   = hs_c & o_tlast;
  assign o_tdata = words_q[0];

  // A push on the cycle the last word is accepted replaces it rather than being dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_q   <= '0;
      left_q    <= '0;
      o_tlast   <= 1'b0;
      o_tvalid  <= 1'b0;
      ovf_count <= '0;
    end else if (clear) begin
      words_q   <= '0;
      left_q    <= '0;
      o_tlast   <= 1'b0;
      o_tvalid  <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (hs_c) begin
        words_q <= words_q >> LEN_W;
        left_q  <= left_q - CW'(1);
        o_tlast <= (left_q == CW'(2));
        if (o_tlast) o_tvalid <= 1'b0;
      end
      if (push) begin
        if (o_tvalid && !fin_c) begin
          if (ovf_count != '1) ovf_count <= ovf_count + OVF_W'(1);
        end else begin
          words_q  <= push_data;
          left_q   <= CW'(WORDS);
          o_tlast  <= (WORDS == 1);
          o_tvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/threshold_trigger_ctrl.sv
// Burst qualifier behind the threshold comparator: on/off/holdoff sequencing, trigger pulse
// and burst-length reports. THRESH_CTRL_TIMESTAMP_EN adds a 64-bit first-sample timestamp.
module threshold_trigger_ctrl
  import threshold_ctrl_pkg::*;
#(
  parameter logic [7:0]  SR_BASE = 8'd0,
  parameter int unsigned LEN_W   = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic             i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [LEN_W-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             trigger,
  output logic             burst_active,
  output logic [15:0]      ovf_count
);

  logic             enable;
  logic [CNT_W-1:0] on_cnt, off_cnt, on_min, off_min;
  logic [31:0]      holdoff;
  state_t           state, state_n;
  logic [CNT_W-1:0] run, run_n, gap, gap_n;
  logic [LEN_W-1:0] len, len_n, len_inc;
  logic [31:0]      hold, hold_n;
  logic             sample, met, trig_n, push_c;
  logic             unused_tlast;
  logic [RPT_WORDS-1:0][LEN_W-1:0] push_data;

  assign i_tready     = 1'b1;
  assign sample       = i_tvalid;
  assign met          = i_tvalid & i_tdata;
  assign on_min       = (on_cnt == '0) ? CNT_W'(1) : on_cnt;
  assign off_min      = (off_cnt == '0) ? CNT_W'(1) : off_cnt;
  assign len_inc      = (len == '1) ? len : len + LEN_W'(1);
  assign unused_tlast = i_tlast;

  // Settings registers; only reset clears them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable  <= 1'b0;
      on_cnt  <= '0;
      off_cnt <= '0;
      holdoff <= '0;
    end else if (set_stb) begin
      case (set_addr)
        8'(SR_BASE + SR_CTRL): enable  <= set_data[0];
        8'(SR_BASE + SR_ON):   on_cnt  <= set_data[CNT_W-1:0];
        8'(SR_BASE + SR_OFF):  off_cnt <= set_data[CNT_W-1:0];
        8'(SR_BASE + SR_HOLD): holdoff <= set_data;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    run_n   = run;
    gap_n   = gap;
    len_n   = len;
    hold_n  = hold;
    trig_n  = 1'b0;
    push_c  = 1'b0;
    if (!enable) begin
      state_n = IDLE;
      run_n   = '0;
      gap_n   = '0;
      len_n   = '0;
      hold_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = SEARCH;
        SEARCH: begin
          if (met) begin
            run_n = CNT_W'(1);
            if (on_min == CNT_W'(1)) begin
              state_n = ACTIVE;
              trig_n  = 1'b1;
              len_n   = LEN_W'(1);
              gap_n   = '0;
            end else begin
              state_n = QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (met) begin
            run_n = run + CNT_W'(1);
            if (run_n >= on_min) begin
              state_n = ACTIVE;
              trig_n  = 1'b1;
              len_n   = LEN_W'(on_min);
              gap_n   = '0;
            end
          end else if (sample) begin
            run_n   = '0;
            state_n = SEARCH;
          end
        end
        // Terminating gap sample is not counted in the reported length
        ACTIVE: begin
          if (met) begin
            gap_n = '0;
            len_n = len_inc;
          end else if (sample) begin
            if (gap + CNT_W'(1) >= off_min) begin
              push_c  = 1'b1;
              run_n   = '0;
              gap_n   = '0;
              len_n   = '0;
              hold_n  = '0;
              state_n = (holdoff == '0) ? SEARCH : HOLDOFF;
            end else begin
              gap_n = gap + CNT_W'(1);
              len_n = len_inc;
            end
          end
        end
        HOLDOFF: begin
          if (sample) begin
            if (hold + 32'd1 >= holdoff) begin
              hold_n  = '0;
              state_n = SEARCH;
            end else begin
              hold_n = hold + 32'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      run          <= '0;
      gap          <= '0;
      len          <= '0;
      hold         <= '0;
      trigger      <= 1'b0;
      burst_active <= 1'b0;
    end else if (clear) begin
      state        <= enable ? SEARCH : IDLE;
      run          <= '0;
      gap          <= '0;
      len          <= '0;
      hold         <= '0;
      trigger      <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      state        <= state_n;
      run          <= run_n;
      gap          <= gap_n;
      len          <= len_n;
      hold         <= hold_n;
      trigger      <= trig_n;
      burst_active <= (state_n == QUALIFY) || (state_n == ACTIVE);
    end
  end

`ifdef THRESH_CTRL_TIMESTAMP_EN
  logic [63:0] sample_cnt, burst_ts;

  // Free-running sample index; the burst start is its value at the first met sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt <= '0;
      burst_ts   <= '0;
    end else if (clear) begin
      sample_cnt <= '0;
      burst_ts   <= '0;
    end else begin
      if (sample) sample_cnt <= sample_cnt + 64'd1;
      if (enable && (state == SEARCH) && met) burst_ts <= sample_cnt;
    end
  end

  assign push_data[0] = len;
  assign push_data[1] = LEN_W'(burst_ts[63:32]);
  assign push_data[2] = LEN_W'(burst_ts[31:0]);
`else
  assign push_data[0] = len;
`endif

  threshold_report_reg #(
    .LEN_W (LEN_W),
    .WORDS (RPT_WORDS)
  ) u_report (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push_c),
    .push_data (push_data),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .ovf_count (ovf_count)
  );

endmodule
